// File: rtl/mvu_pe_popcount_acc.sv
// Folds one PE's per-beat popcount sums over SF beats into one word per matrix row.
// The result sits in a single valid/ready holding register. A sticky flag records any modulo wrap.
module mvu_pe_popcount_acc #(
    parameter int SIMD  = 8,
    parameter int SF    = 4,
    parameter int TDstI = 16,
    parameter int TO    = 24
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             in_v,
    output logic             in_rdy,
    input  logic [TDstI-1:0] in_add,
    output logic             out_v,
    input  logic             out_rdy,
    output logic [TO-1:0]    out_acc,
    output logic             ovf
);

    localparam int CW = (SF > 1) ? $clog2(SF) : 1;
    localparam logic [CW-1:0] LAST = CW'(SF - 1);

    if (SF < 1 || TO < TDstI || SIMD < 1) begin : g_param_check
        $error("mvu_pe_popcount_acc: requires SF >= 1, SIMD >= 1, TO >= TDstI");
    end

    typedef enum logic {S_ACC, S_FULL} state_t;

    state_t        state, state_nxt;
    logic [TO-1:0] acc;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          final_beat;
    logic [TO-1:0] base;
    logic [TO-1:0] add_ext;
    logic [TO:0]   sum;

    assign out_v      = (state == S_FULL);
    assign in_rdy     = !out_v || out_rdy;
    assign accept     = in_v && in_rdy;
    assign final_beat = accept && (cnt == LAST);

    // The first beat of a row loads rather than adds, so no stale carry leaks in from the previous row.
    assign base    = (cnt == '0) ? '0 : acc;
    assign add_ext = TO'(in_add);
    assign sum     = {1'b0, base} + {1'b0, add_ext};

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        state_nxt = state;
        case (state)
            S_ACC:   if (final_beat) state_nxt = S_FULL;
            S_FULL:  if (out_rdy && !final_beat) state_nxt = S_ACC;
            default: state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_ACC;
        else          state <= state_nxt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc     <= '0;
            cnt     <= '0;
            out_acc <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments let each register see the pre-edge values of the others.
            cnt <= final_beat ? '0 : cnt + 1'b1;
            if (final_beat) out_acc <= sum[TO-1:0];
            else            acc     <= sum[TO-1:0];
            if (sum[TO]) ovf <= 1'b1;
        end
    end

    // A held word must stay put until the consumer takes it.
    a_hold_stable: assert property (@(posedge aclk) disable iff (!aresetn)
        out_v && !out_rdy |=> out_v && $stable(out_acc));

endmodule

// File: tb/tb_mvu_pe_popcount_acc.sv
// Scoreboard bench for mvu_pe_popcount_acc: three instances (SF=4/TO=24, SF=1, SF=2/TO=16)
// driven with directed rows; per-instance monitors pop expected words as they are handshaken.
module tb_mvu_pe_popcount_acc;

    typedef struct {
        logic [23:0] acc;
        logic        ovf;
        int          gap;   // required cycles since the previous word; 0 = don't care
    } exp_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge aclk) cyc++;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // instance a: SF=4, TDstI=16, TO=24
    logic        a_in_v = 1'b0, a_in_rdy, a_out_v, a_out_rdy = 1'b1, a_ovf;
    logic [15:0] a_in_add = '0;
    logic [23:0] a_out_acc;
    // instance b: SF=1
    logic        b_in_v = 1'b0, b_in_rdy, b_out_v, b_out_rdy = 1'b1, b_ovf;
    logic [15:0] b_in_add = '0;
    logic [23:0] b_out_acc;
    // instance c: SF=2, TO=16 (wraps)
    logic        c_in_v = 1'b0, c_in_rdy, c_out_v, c_out_rdy = 1'b1, c_ovf;
    logic [15:0] c_in_add = '0;
    logic [15:0] c_out_acc;

    mvu_pe_popcount_acc #(.SIMD(8), .SF(4), .TDstI(16), .TO(24)) u_a (
        .aclk(aclk), .aresetn(aresetn), .in_v(a_in_v), .in_rdy(a_in_rdy), .in_add(a_in_add),
        .out_v(a_out_v), .out_rdy(a_out_rdy), .out_acc(a_out_acc), .ovf(a_ovf));

    mvu_pe_popcount_acc #(.SIMD(8), .SF(1), .TDstI(16), .TO(24)) u_b (
        .aclk(aclk), .aresetn(aresetn), .in_v(b_in_v), .in_rdy(b_in_rdy), .in_add(b_in_add),
        .out_v(b_out_v), .out_rdy(b_out_rdy), .out_acc(b_out_acc), .ovf(b_ovf));

    mvu_pe_popcount_acc #(.SIMD(8), .SF(2), .TDstI(16), .TO(16)) u_c (
        .aclk(aclk), .aresetn(aresetn), .in_v(c_in_v), .in_rdy(c_in_rdy), .in_add(c_in_add),
        .out_v(c_out_v), .out_rdy(c_out_rdy), .out_acc(c_out_acc), .ovf(c_ovf));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    task automatic drive(input int u, input logic v, input logic [15:0] d);
        case (u)
            0:       begin a_in_v = v; a_in_add = d; end
            1:       begin b_in_v = v; b_in_add = d; end
            default: begin c_in_v = v; c_in_add = d; end
        endcase
    endtask

    function automatic logic rdy(input int u);
        case (u)
            0:       return a_in_rdy;
            1:       return b_in_rdy;
            default: return c_in_rdy;
        endcase
    endfunction

    // Offer one beat from a falling edge; returns just after the rising edge that accepts it.
    task automatic beat(input int u, input logic [15:0] v);
        logic done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge aclk);
            drive(u, 1'b1, v);
            #4;
            done = rdy(u);
            @(posedge aclk);
        end
        if (!done) fail($sformatf("beat accept timeout unit %0d", u));
    endtask

    task automatic idle(input int u);
        @(negedge aclk);
        drive(u, 1'b0, 'x);
    endtask

    task automatic push(input int u, input logic [23:0] acc, input logic ovf, input int gap);
        exp_t e;
        e.acc = acc; e.ovf = ovf; e.gap = gap;
        case (u)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic cmp_word(input string nm, input exp_t e, input logic [23:0] acc,
                            input logic ovf, input int gap);
        check({nm, " out_acc"}, acc, e.acc);
        check({nm, " ovf"}, ovf, e.ovf);
        if (e.gap > 0) check({nm, " word spacing"}, gap, e.gap);
    endtask

    initial begin : mon_a
        int last = 0;
        logic pv = 1'b0, pr = 1'b0;
        logic [23:0] pacc = '0;
        forever begin
            @(negedge aclk); #4;
            if (aresetn && pv && !pr) begin
                check("a stall out_v", a_out_v, 1);
                check("a stall out_acc", a_out_acc, pacc);
            end
            if (aresetn && a_out_v && a_out_rdy) begin
                if (qa.size() == 0) fail("a unexpected word");
                else cmp_word("a", qa.pop_front(), a_out_acc, a_ovf, cyc - last);
                last = cyc;
            end
            pv = aresetn && a_out_v; pr = a_out_rdy; pacc = a_out_acc;
        end
    end

    initial begin : mon_b
        int last = 0;
        forever begin
            @(negedge aclk); #4;
            if (aresetn && b_out_v && b_out_rdy) begin
                if (qb.size() == 0) fail("b unexpected word");
                else cmp_word("b", qb.pop_front(), b_out_acc, b_ovf, cyc - last);
                last = cyc;
            end
        end
    end

    initial begin : mon_c
        int last = 0;
        forever begin
            @(negedge aclk); #4;
            if (aresetn && c_out_v && c_out_rdy) begin
                if (qc.size() == 0) fail("c unexpected word");
                else cmp_word("c", qc.pop_front(), 24'(c_out_acc), c_ovf, cyc - last);
                last = cyc;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // reset state
        #12;
        check("reset a out_v", a_out_v, 0);
        check("reset a out_acc", a_out_acc, 0);
        check("reset a ovf", a_ovf, 0);
        check("reset a in_rdy", a_in_rdy, 1);
        @(negedge aclk);
        aresetn = 1'b1;

        // 1: single row, latency of one cycle after the final beat
        push(0, 24'd16, 1'b0, 0);
        beat(0, 16'd3); beat(0, 16'd5); beat(0, 16'd7);
        #1 check("t1 out_v before final beat", a_out_v, 0);
        beat(0, 16'd1);
        #1 check("t1 out_v after final beat", a_out_v, 1);
        check("t1 out_acc", a_out_acc, 16);

        // 2: back-to-back rows, words SF cycles apart
        push(0, 24'd4, 1'b0, 0);
        push(0, 24'd8, 1'b0, 4);
        for (int i = 0; i < 4; i++) beat(0, 16'd1);
        for (int i = 0; i < 4; i++) beat(0, 16'd2);
        idle(0); idle(0);

        // 3: backpressure with the next row offered during the stall
        a_out_rdy = 1'b0;
        push(0, 24'd40, 1'b0, 0);
        push(0, 24'd12, 1'b0, 0);
        for (int i = 0; i < 4; i++) beat(0, 16'd10);
        fork
            begin
                for (int i = 0; i < 4; i++) beat(0, 16'd3);
                idle(0);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge aclk); #4;
                    check("t3 stall in_rdy", a_in_rdy, 0);
                    check("t3 stall out_acc", a_out_acc, 40);
                end
                @(negedge aclk);
                a_out_rdy = 1'b1;
            end
        join
        idle(0);

        // 4: SF=1, one word per beat
        push(1, 24'd9, 1'b0, 0);
        push(1, 24'd0, 1'b0, 1);
        push(1, 24'd65535, 1'b0, 1);
        beat(1, 16'd9); beat(1, 16'd0); beat(1, 16'hFFFF);
        idle(1); idle(1);

        // 5: wrap at TO=16, sticky ovf
        push(2, 24'd0, 1'b1, 0);
        push(2, 24'd5, 1'b1, 0);
        push(2, 24'd100, 1'b1, 0);
        beat(2, 16'hFFFF); beat(2, 16'd1);
        beat(2, 16'd2); beat(2, 16'd3);
        beat(2, 16'd60); beat(2, 16'd40);
        idle(2); idle(2);

        // 6: asynchronous reset mid-row discards the partial sum
        beat(0, 16'd5); beat(0, 16'd5);
        @(negedge aclk);
        a_in_v = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check("t6 reset a out_v", a_out_v, 0);
        check("t6 reset a out_acc", a_out_acc, 0);
        check("t6 reset a ovf", a_ovf, 0);
        check("t6 reset c ovf", c_ovf, 0);
        check("t6 reset c out_acc", c_out_acc, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        push(0, 24'd10, 1'b0, 0);
        beat(0, 16'd1); beat(0, 16'd2); beat(0, 16'd3); beat(0, 16'd4);
        for (int i = 0; i < 4; i++) idle(0);

        check("a words drained", qa.size(), 0);
        check("b words drained", qb.size(), 0);
        check("c words drained", qc.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
